// File: rtl/qtree_nat_serializer_pkg.sv
// Shared QTree_Nat types: heap word, pointer, tags, traversal frame, FSM state and field helpers.
package qtree_nat_serializer_pkg;

    localparam int PTR_W          = 16;
    localparam int WORD_W         = 67;
    localparam int QT_STACK_DEPTH = 256;

    typedef logic [WORD_W-1:0] qtree_nat_t;
    typedef logic [PTR_W-1:0]  pointer_qtree_nat_t;

    localparam logic [1:0] TAG_QNONE  = 2'd0;
    localparam logic [1:0] TAG_QVAL   = 2'd1;
    localparam logic [1:0] TAG_QNODE  = 2'd2;
    localparam logic [1:0] TAG_QERROR = 2'd3;

    typedef struct packed {
        qtree_nat_t word;
        logic [2:0] next_child;
    } frame_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DESCEND,
        S_EMIT
    } state_t;

    // A word whose valid bit is clear is always treated as QError.
    function automatic logic [1:0] node_tag(input qtree_nat_t w);
        return w[0] ? w[2:1] : TAG_QERROR;
    endfunction

    function automatic pointer_qtree_nat_t child_ptr(input qtree_nat_t w, input logic [1:0] idx);
        return w[3 + PTR_W*int'(idx) +: PTR_W];
    endfunction

    function automatic qtree_nat_t qnode_nat_dc(input qtree_nat_t w);
        return {{(WORD_W-3){1'b0}}, w[2:0]};
    endfunction

endpackage

// File: rtl/qtree_nat_serializer_stack.sv
// LIFO of traversal frames; bump advances next_child of the top frame in place.
module qtree_frame_stack
    import qtree_nat_serializer_pkg::*;
#(
    parameter int DEPTH = QT_STACK_DEPTH,
    localparam int SP_W = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            aresetn,
    input  logic            clear,
    input  logic            push,
    input  logic            pop,
    input  logic            bump,
    input  frame_t          push_frame,
    output frame_t          top_frame,
    output logic [SP_W-1:0] sp,
    output logic            empty,
    output logic            full
);

    localparam int IDX_W = SP_W - 1;
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [SP_W-1:0]  SP_ONE  = SP_W'(1);
    localparam logic [SP_W-1:0]  SP_LAST = SP_W'(DEPTH - 1);

    frame_t           mem [DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;

    assign wr_idx    = sp[IDX_W-1:0];
    assign top_idx   = wr_idx - IDX_ONE;
    assign top_frame = mem[top_idx];
    assign empty     = (sp == '0);
    assign full      = (sp == SP_LAST);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)   sp <= '0;
        else if (clear) sp <= '0;
        else if (push)  sp <= sp + SP_ONE;
        else if (pop)   sp <= sp - SP_ONE;
    end

    always_ff @(posedge clk) begin
        if (push)      mem[wr_idx] <= push_frame;
        else if (bump) mem[top_idx].next_child <= mem[top_idx].next_child + 3'd1;
    end

endmodule

// File: rtl/qtree_nat_serializer.sv
// Post-order QTree_Nat heap walker feeding an AXI-stream; one beat per node, tlast on the root.
// Optional statistics outputs are built when QTREE_SER_STATS_EN is defined.
module qtree_nat_serializer
    import qtree_nat_serializer_pkg::*;
#(
    parameter int STACK_DEPTH = QT_STACK_DEPTH
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic [PTR_W-1:0]  root_data,
    input  logic              root_valid,
    output logic              root_ready,
    output logic [PTR_W-1:0]  mem_rd_addr,
    output logic              mem_rd_req,
    input  logic              mem_rd_gnt,
    input  logic [WORD_W-1:0] mem_rd_data,
    input  logic              mem_rd_dvalid,
    output logic [WORD_W-1:0] o_QTree_Nat_tdata,
    output logic              o_QTree_Nat_tlast,
    output logic              o_QTree_Nat_tvalid,
    input  logic              o_QTree_Nat_tready,
    output logic              overflow,
`ifdef QTREE_SER_STATS_EN
    output logic [31:0]       beat_count,
    output logic [31:0]       node_count,
    output logic [$clog2(STACK_DEPTH):0] max_depth,
`endif
    output logic              busy
);

    localparam int SP_W = $clog2(STACK_DEPTH) + 1;
    localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);

    state_t          state;
    logic            emit_pop;
    frame_t          top_frame;
    frame_t          push_frame;
    logic [SP_W-1:0] sp;
    logic            st_empty, st_full, st_clear;
    logic            push, pop, bump;
    logic [1:0]      rsp_tag;
    logic            rsp_node, beat_acc;

    assign rsp_tag    = node_tag(mem_rd_data);
    assign rsp_node   = (state == S_WAIT) && mem_rd_dvalid && (rsp_tag == TAG_QNODE);
    assign push       = rsp_node && !st_full;
    assign st_clear   = rsp_node && st_full;
    assign bump       = (state == S_DESCEND) && !top_frame.next_child[2];
    assign beat_acc   = (state == S_EMIT) && o_QTree_Nat_tready;
    assign pop        = beat_acc && emit_pop;
    assign push_frame = '{word: mem_rd_data, next_child: 3'd0};

    qtree_frame_stack #(.DEPTH(STACK_DEPTH)) u_stack (
        .clk        (clk),
        .aresetn    (aresetn),
        .clear      (st_clear),
        .push       (push),
        .pop        (pop),
        .bump       (bump),
        .push_frame (push_frame),
        .top_frame  (top_frame),
        .sp         (sp),
        .empty      (st_empty),
        .full       (st_full)
    );

    // IDLE wait root | FETCH hold req | WAIT response | DESCEND next child or node beat | EMIT hold beat
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state              <= S_IDLE;
            root_ready         <= 1'b1;
            busy               <= 1'b0;
            mem_rd_addr        <= '0;
            mem_rd_req         <= 1'b0;
            o_QTree_Nat_tdata  <= '0;
            o_QTree_Nat_tlast  <= 1'b0;
            o_QTree_Nat_tvalid <= 1'b0;
            overflow           <= 1'b0;
            emit_pop           <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (root_valid) begin
                    root_ready  <= 1'b0;
                    busy        <= 1'b1;
                    mem_rd_addr <= root_data;
                    mem_rd_req  <= 1'b1;
                    state       <= S_FETCH;
                end
                S_FETCH: if (mem_rd_gnt) begin
                    mem_rd_req <= 1'b0;
                    state      <= S_WAIT;
                end
                S_WAIT: if (mem_rd_dvalid) begin
                    if (rsp_tag != TAG_QNODE) begin
                        o_QTree_Nat_tdata  <= mem_rd_data[0] ? mem_rd_data
                                              : {mem_rd_data[WORD_W-1:3], TAG_QERROR, 1'b1};
                        o_QTree_Nat_tlast  <= st_empty;
                        o_QTree_Nat_tvalid <= 1'b1;
                        emit_pop           <= 1'b0;
                        state              <= S_EMIT;
                    end else if (st_full) begin
                        overflow   <= 1'b1;
                        busy       <= 1'b0;
                        root_ready <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        state <= S_DESCEND;
                    end
                end
                S_DESCEND: if (!top_frame.next_child[2]) begin
                    mem_rd_addr <= child_ptr(top_frame.word, top_frame.next_child[1:0]);
                    mem_rd_req  <= 1'b1;
                    state       <= S_FETCH;
                end else begin
                    o_QTree_Nat_tdata  <= qnode_nat_dc(top_frame.word);
                    o_QTree_Nat_tlast  <= (sp == SP_ONE);
                    o_QTree_Nat_tvalid <= 1'b1;
                    emit_pop           <= 1'b1;
                    state              <= S_EMIT;
                end
                S_EMIT: if (o_QTree_Nat_tready) begin
                    o_QTree_Nat_tvalid <= 1'b0;
                    if (o_QTree_Nat_tlast) begin
                        busy       <= 1'b0;
                        root_ready <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        state <= S_DESCEND;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef QTREE_SER_STATS_EN
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            beat_count <= '0;
            node_count <= '0;
            max_depth  <= '0;
        end else if (state == S_IDLE && root_valid) begin
            beat_count <= '0;
            node_count <= '0;
            max_depth  <= '0;
        end else begin
            if (beat_acc && beat_count != '1) beat_count <= beat_count + 32'd1;
            if (pop && node_count != '1)      node_count <= node_count + 32'd1;
            if (push && (sp + SP_ONE) > max_depth && max_depth != '1) max_depth <= sp + SP_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_qtree_nat_serializer.sv
// Directed bench for qtree_nat_serializer with a heap responder and a beat/stall monitor.
module tb_qtree_nat_serializer;
    import qtree_nat_serializer_pkg::*;

    logic              clk = 1'b0;
    logic              aresetn;
    logic [PTR_W-1:0]  root_data;
    logic              root_valid;
    logic              root_ready;
    logic [PTR_W-1:0]  mem_rd_addr;
    logic              mem_rd_req;
    logic              mem_rd_gnt;
    logic [WORD_W-1:0] mem_rd_data;
    logic              mem_rd_dvalid;
    logic [WORD_W-1:0] o_QTree_Nat_tdata;
    logic              o_QTree_Nat_tlast;
    logic              o_QTree_Nat_tvalid;
    logic              o_QTree_Nat_tready;
    logic              overflow;
    logic              busy;
`ifdef QTREE_SER_STATS_EN
    logic [31:0]       beat_count;
    logic [31:0]       node_count;
    logic [8:0]        max_depth;
`endif

    qtree_nat_serializer dut (
        .clk                (clk),
        .aresetn            (aresetn),
        .root_data          (root_data),
        .root_valid         (root_valid),
        .root_ready         (root_ready),
        .mem_rd_addr        (mem_rd_addr),
        .mem_rd_req         (mem_rd_req),
        .mem_rd_gnt         (mem_rd_gnt),
        .mem_rd_data        (mem_rd_data),
        .mem_rd_dvalid      (mem_rd_dvalid),
        .o_QTree_Nat_tdata  (o_QTree_Nat_tdata),
        .o_QTree_Nat_tlast  (o_QTree_Nat_tlast),
        .o_QTree_Nat_tvalid (o_QTree_Nat_tvalid),
        .o_QTree_Nat_tready (o_QTree_Nat_tready),
        .overflow           (overflow),
`ifdef QTREE_SER_STATS_EN
        .beat_count         (beat_count),
        .node_count         (node_count),
        .max_depth          (max_depth),
`endif
        .busy               (busy)
    );

    always #5 clk = ~clk;

    logic [WORD_W-1:0] heap [0:1023];
    logic              gnt_en;
    assign mem_rd_gnt = gnt_en;

    // One-cycle in-order read responder.
    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            mem_rd_dvalid <= 1'b0;
            mem_rd_data   <= '0;
        end else if (mem_rd_req && mem_rd_gnt) begin
            mem_rd_dvalid <= 1'b1;
            mem_rd_data   <= heap[mem_rd_addr[9:0]];
        end else begin
            mem_rd_dvalid <= 1'b0;
        end
    end

    logic [WORD_W-1:0] bdata [$];
    logic              blast [$];
    int                stall_err = 0;
    logic              prev_stall = 1'b0;
    logic [WORD_W-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (o_QTree_Nat_tvalid !== 1'b1 || o_QTree_Nat_tdata !== prev_data))
                stall_err++;
            prev_stall = o_QTree_Nat_tvalid && !o_QTree_Nat_tready;
            prev_data  = o_QTree_Nat_tdata;
            if (o_QTree_Nat_tvalid && o_QTree_Nat_tready) begin
                bdata.push_back(o_QTree_Nat_tdata);
                blast.push_back(o_QTree_Nat_tlast);
            end
        end
    end

    int tests  = 0;
    int failed = 0;
    bit to;

    localparam logic [WORD_W-1:0] NODE_DC = {64'd0, TAG_QNODE, 1'b1};

    function automatic logic [WORD_W-1:0] w_val(input int v);
        return {64'(v), TAG_QVAL, 1'b1};
    endfunction

    function automatic logic [WORD_W-1:0] w_node(input logic [15:0] c0, c1, c2, c3);
        return {c3, c2, c1, c0, TAG_QNODE, 1'b1};
    endfunction

    task automatic check(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input int k, input logic [WORD_W-1:0] exp_d, input logic exp_l);
        check({tag, "_data"}, (k < bdata.size()) ? bdata[k] : '1, exp_d);
        check({tag, "_last"}, (k < blast.size()) ? {{(WORD_W-1){1'b0}}, blast[k]} : '1,
              {{(WORD_W-1){1'b0}}, exp_l});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_beats();
        bdata.delete();
        blast.delete();
    endtask

    task automatic send_root(input logic [15:0] p);
        root_data  = p;
        root_valid = 1'b1;
        step();
        root_valid = 1'b0;
    endtask

    // mode 0: tready always high; mode 1: tready 1,0,1,0...
    task automatic run(input int mode, input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            o_QTree_Nat_tready = (mode == 0) ? 1'b1 : (i % 2 == 0);
            step();
            if (!busy && !o_QTree_Nat_tvalid) begin
                timed_out = 1'b0;
                break;
            end
        end
        o_QTree_Nat_tready = 1'b1;
    endtask

    initial begin
        aresetn            = 1'b0;
        root_valid         = 1'b0;
        root_data          = '0;
        gnt_en             = 1'b1;
        o_QTree_Nat_tready = 1'b1;
        for (int a = 0; a < 1024; a++) heap[a] = '0;
        heap[10] = w_val(5);
        heap[20] = w_node(16'd21, 16'd22, 16'd23, 16'd24);
        for (int k = 0; k < 4; k++) heap[21+k] = w_val(k + 1);
        heap[40] = w_node(16'd41, 16'd42, 16'd43, 16'd44);
        for (int i = 0; i < 4; i++) begin
            heap[41+i] = w_node(16'(50+4*i), 16'(51+4*i), 16'(52+4*i), 16'(53+4*i));
            for (int j = 0; j < 4; j++) heap[50+4*i+j] = w_val(101 + 4*i + j);
        end
        for (int a = 200; a < 500; a++) heap[a] = w_node(16'(a + 1), 16'd0, 16'd0, 16'd0);

        step();
        check("rst_root_ready", root_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_tvalid", o_QTree_Nat_tvalid, 0);
        check("rst_req", mem_rd_req, 0);
        check("rst_overflow", overflow, 0);
        step();
        aresetn = 1'b1;
        step();

        // single QVal leaf
        clear_beats();
        send_root(16'd10);
        check("t1_req_latency", mem_rd_req, 1);
        check("t1_addr", mem_rd_addr, 10);
        check("t1_busy", busy, 1);
        check("t1_root_ready_low", root_ready, 0);
        run(0, 50, to);
        check("t1_timeout", to, 0);
        check("t1_count", bdata.size(), 1);
        check_beat("t1_b0", 0, w_val(5), 1'b1);
        check("t1_root_ready", root_ready, 1);

        // QNode with four QVal leaves
        clear_beats();
        send_root(16'd20);
        run(0, 200, to);
        check("t2_timeout", to, 0);
        check("t2_count", bdata.size(), 5);
        for (int k = 0; k < 4; k++) check_beat("t2_leaf", k, w_val(k + 1), 1'b0);
        check_beat("t2_node", 4, NODE_DC, 1'b1);
`ifdef QTREE_SER_STATS_EN
        check("t2_beat_count", beat_count, 5);
        check("t2_node_count", node_count, 1);
        check("t2_max_depth", max_depth, 1);
`endif

        // grant withheld
        clear_beats();
        gnt_en = 1'b0;
        send_root(16'd10);
        for (int k = 0; k < 10; k++) begin
            check("gnt_req_held", mem_rd_req, 1);
            check("gnt_addr_held", mem_rd_addr, 10);
            check("gnt_no_beat", o_QTree_Nat_tvalid, 0);
            step();
        end
        gnt_en = 1'b1;
        run(0, 50, to);
        check("gnt_timeout", to, 0);
        check("gnt_count", bdata.size(), 1);
        check_beat("gnt_b0", 0, w_val(5), 1'b1);

        // depth-3 tree with tready toggling
        clear_beats();
        stall_err = 0;
        send_root(16'd40);
        run(1, 3000, to);
        check("t3_timeout", to, 0);
        check("t3_count", bdata.size(), 21);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) check_beat("t3_leaf", 5*i + j, w_val(101 + 4*i + j), 1'b0);
            check_beat("t3_node", 5*i + 4, NODE_DC, 1'b0);
        end
        check_beat("t3_root", 20, NODE_DC, 1'b1);
        check("t3_stall_stable", stall_err, 0);

        // chain deeper than the stack
        clear_beats();
        send_root(16'd200);
        run(0, 5000, to);
        check("ovf_timeout", to, 0);
        check("ovf_flag", overflow, 1);
        check("ovf_no_beats", bdata.size(), 0);
        check("ovf_root_ready", root_ready, 1);
        check("ovf_busy", busy, 0);

        // reset while a beat is stalled
        clear_beats();
        send_root(16'd40);
        o_QTree_Nat_tready = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (o_QTree_Nat_tvalid) break;
            step();
        end
        check("rstm_pre_tvalid", o_QTree_Nat_tvalid, 1);
        aresetn = 1'b0;
        #1;
        check("rstm_tvalid", o_QTree_Nat_tvalid, 0);
        check("rstm_root_ready", root_ready, 1);
        check("rstm_busy", busy, 0);
        check("rstm_overflow", overflow, 0);
        step();
        step();
        aresetn = 1'b1;
        o_QTree_Nat_tready = 1'b1;
        step();
        clear_beats();
        send_root(16'd20);
        run(0, 200, to);
        check("rstm_timeout", to, 0);
        check("rstm_count", bdata.size(), 5);
        for (int k = 0; k < 4; k++) check_beat("rstm_leaf", k, w_val(k + 1), 1'b0);
        check_beat("rstm_node", 4, NODE_DC, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
